// File: rtl/spi_master_param.sv
// Parametrised SPI master: DW-bit words, CLK_DIV clk cycles per SCK half-period, per-transfer CPOL/CPHA, NSS selects.
// Optional macro SPI_LOOPBACK_EN: receive register samples the internal MOSI instead of the MISO pin.
module spi_master_param #(
   parameter  int unsigned DW      = 8,
   parameter  int unsigned CLK_DIV = 4,
   parameter  int unsigned NSS     = 2,
   localparam int unsigned SW      = (NSS > 1) ? $clog2(NSS) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [DW-1:0]  din,
   input  logic           en,
   input  logic           cpol,
   input  logic           cpha,
   input  logic [SW-1:0]  ss_idx,
   input  logic           MISO,
   output logic           MOSI,
   output logic           SCK,
   output logic [NSS-1:0] SS,
   output logic           busy,
   output logic [DW-1:0]  dout,
   output logic           valid
);
   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned NE = 2 * DW;
   localparam int unsigned EW = $clog2(NE + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [EW-1:0]  ecnt_q, ecnt_d;
   logic [DW-1:0]  tx_q, tx_d;
   logic [DW-1:0]  rx_q, rx_d;
   logic [DW-1:0]  dout_q, dout_d;
   logic [NSS-1:0] ss_q, ss_d;
   logic           cpol_q, cpol_d;
   logic           cpha_q, cpha_d;
   logic           sck_q, sck_d;
   logic           mosi_q, mosi_d;
   logic           busy_q, busy_d;
   logic           valid_q, valid_d;
   logic           rx_bit_c;
   logic           tick_c;
   logic [EW-1:0]  ecnt_n_c;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = MISO;
   assign rx_bit_c    = mosi_q;
`else
   assign rx_bit_c    = MISO;
`endif

   assign tick_c   = (cnt_q == CW'(CLK_DIV - 1));
   assign ecnt_n_c = ecnt_q + EW'(1);

   // Next-state and registered-output logic; ecnt_n_c is the number of the SCK edge taken on this tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ecnt_d  = ecnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      ss_d    = ss_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ss_d    = '1;
            sck_d   = cpol_q;
            mosi_d  = 1'b0;
            if (en) begin
               state_d = S_SETUP;
               busy_d  = 1'b1;
               cnt_d   = '0;
               ecnt_d  = '0;
               tx_d    = din;
               rx_d    = '0;
               cpol_d  = cpol;
               cpha_d  = cpha;
               sck_d   = cpol;
               mosi_d  = cpha ? 1'b0 : din[DW-1];
               for (int i = 0; i < NSS; i++) begin
                  ss_d[i] = (32'(ss_idx) != 32'(i));
               end
            end
         end
         S_SETUP, S_SHIFT: begin
            cnt_d = cnt_q + CW'(1);
            if (tick_c) begin
               cnt_d   = '0;
               ecnt_d  = ecnt_n_c;
               sck_d   = ~sck_q;
               state_d = (ecnt_n_c == EW'(NE)) ? S_HOLD : S_SHIFT;
               if (ecnt_n_c[0] != cpha_q) begin
                  rx_d = {rx_q[DW-2:0], rx_bit_c};
               end else if (cpha_q) begin
                  mosi_d = tx_q[DW-1];
                  tx_d   = tx_q << 1;
               end else if (ecnt_n_c != EW'(NE)) begin
                  mosi_d = tx_q[DW-2];
                  tx_d   = tx_q << 1;
               end
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + CW'(1);
            if (tick_c) begin
               state_d = S_DONE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               ss_d    = '1;
               valid_d = 1'b1;
               dout_d  = rx_q;
               mosi_d  = 1'b0;
               sck_d   = cpol_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ecnt_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         ss_q    <= '1;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ecnt_q  <= ecnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         ss_q    <= ss_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign MOSI  = mosi_q;
   assign SCK   = sck_q;
   assign SS    = ss_q;
   assign busy  = busy_q;
   assign dout  = dout_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: instance A (DW=8, CLK_DIV=4, NSS=4) against a bit-level slave model,
// instance B (DW=16, CLK_DIV=1, NSS=3) with MISO wired to MOSI for back-to-back and out-of-range select.
module tb_spi_master_param;
   localparam int unsigned CD_A = 4;

`ifdef SPI_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   typedef struct {
      logic       cpol;
      logic       cpha;
      logic [1:0] idx;
      logic [7:0] din;
      logic [7:0] sl;
      logic [7:0] exp;
      logic [3:0] ss;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   logic [7:0]  din_a = '0;
   logic        en_a = 1'b0, cpol_a = 1'b0, cpha_a = 1'b0;
   logic [1:0]  idx_a = '0;
   logic        miso_a = 1'b0;
   logic        mosi_a, sck_a, busy_a, valid_a;
   logic [3:0]  ss_a;
   logic [7:0]  dout_a;

   logic [15:0] din_b = '0;
   logic        en_b = 1'b0, cpol_b = 1'b0, cpha_b = 1'b0;
   logic [1:0]  idx_b = '0;
   logic        miso_b, mosi_b, sck_b, busy_b, valid_b;
   logic [2:0]  ss_b;
   logic [15:0] dout_b;

   int          vcnt_a = 0;
   int          vcnt_b = 0;

   spi_master_param #(.DW(8), .CLK_DIV(CD_A), .NSS(4)) u_a (
      .clk(clk), .rst_n(rst_n), .din(din_a), .en(en_a), .cpol(cpol_a), .cpha(cpha_a),
      .ss_idx(idx_a), .MISO(miso_a), .MOSI(mosi_a), .SCK(sck_a), .SS(ss_a),
      .busy(busy_a), .dout(dout_a), .valid(valid_a)
   );

   spi_master_param #(.DW(16), .CLK_DIV(1), .NSS(3)) u_b (
      .clk(clk), .rst_n(rst_n), .din(din_b), .en(en_b), .cpol(cpol_b), .cpha(cpha_b),
      .ss_idx(idx_b), .MISO(miso_b), .MOSI(mosi_b), .SCK(sck_b), .SS(ss_b),
      .busy(busy_b), .dout(dout_b), .valid(valid_b)
   );

   assign miso_b = mosi_b;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (valid_a === 1'b1) vcnt_a++;
      if (valid_b === 1'b1) vcnt_b++;
   end

   // Slave model for instance A: shifts on the non-sampling edges, samples MOSI on the sampling edges
   logic       sl_act = 1'b0;
   logic       sl_cpha = 1'b0;
   logic [1:0] sl_sel = '0;
   logic [7:0] sl_data = '0;
   logic [7:0] sl_sr = '0;
   logic [7:0] sl_rx = '0;
   logic       sck_prev = 1'b0;
   int         sl_cnt = 0;

   always @(posedge clk) begin
      #1;
      if (!sl_act && ss_a[sl_sel] === 1'b0) begin
         sl_act = 1'b1;
         sl_cnt = 0;
         sl_sr  = sl_data;
         sl_rx  = '0;
         miso_a = sl_cpha ? 1'b0 : sl_data[7];
      end else if (sl_act && ss_a[sl_sel] === 1'b1) begin
         sl_act = 1'b0;
      end else if (sl_act && sck_a !== sck_prev) begin
         sl_cnt++;
         if (sl_cnt[0] != sl_cpha) begin
            sl_rx = {sl_rx[6:0], mosi_a};
         end else if (sl_cpha) begin
            miso_a = sl_sr[7];
            sl_sr  = sl_sr << 1;
         end else begin
            sl_sr  = sl_sr << 1;
            miso_a = sl_sr[7];
         end
      end
      sck_prev = sck_a;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One transfer on instance A; glitch>0 re-pulses en with different din/mode/index at that cycle offset.
   task automatic run_a(input vec_t v, input int glitch);
      int         t0;
      int         vc0;
      logic [7:0] exp_d;
      exp_d = LB ? v.din : v.exp;
      @(negedge clk);
      din_a = v.din; cpol_a = v.cpol; cpha_a = v.cpha; idx_a = v.idx;
      sl_data = v.sl; sl_cpha = v.cpha; sl_sel = v.idx;
      en_a = 1'b1;
      t0 = cyc;
      vc0 = vcnt_a;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         en_a = 1'b0;
         if (glitch > 0 && c == glitch) begin
            en_a = 1'b1; din_a = 8'hFF; cpol_a = ~v.cpol; cpha_a = ~v.cpha; idx_a = 2'd0;
         end
         if (c == 1) begin
            chk("a_busy_start", 32'(busy_a), 32'(1'b1));
            chk("a_ss_start", 32'(ss_a), 32'(v.ss));
            chk("a_sck_setup", 32'(sck_a), 32'(v.cpol));
         end
         if (c == CD_A) chk("a_sck_before_edge1", 32'(sck_a), 32'(v.cpol));
         if (c == CD_A + 1) chk("a_sck_edge1", 32'(sck_a), 32'(!v.cpol));
         if (c == 68) begin
            chk("a_busy_hold", 32'(busy_a), 32'(1'b1));
            chk("a_ss_hold", 32'(ss_a), 32'(v.ss));
            chk("a_valid_early", 32'(valid_a), 32'(1'b0));
            chk("a_sck_hold", 32'(sck_a), 32'(v.cpol));
         end
         if (c == 69) begin
            chk("a_valid_done", 32'(valid_a), 32'(1'b1));
            chk("a_busy_done", 32'(busy_a), 32'(1'b0));
            chk("a_ss_done", 32'(ss_a), 32'hF);
            chk("a_dout", 32'(dout_a), 32'(exp_d));
            chk("slave_rx", 32'(sl_rx), 32'(v.din));
         end
         if (c == 70) begin
            chk("a_valid_pulse", 32'(valid_a), 32'(1'b0));
            chk("a_mosi_idle", 32'(mosi_a), 32'(1'b0));
            chk("a_dout_held", 32'(dout_a), 32'(exp_d));
         end
      end
      chk("a_valid_count", 32'(vcnt_a - vc0), 32'd1);
   endtask

   vec_t vecs[6];
   vec_t vg;

   initial begin
      int t0;
      int vc0;
      vecs[0] = '{cpol: 1'b0, cpha: 1'b0, idx: 2'd0, din: 8'h55, sl: 8'hAA, exp: 8'hAA, ss: 4'b1110};
      vecs[1] = '{cpol: 1'b0, cpha: 1'b0, idx: 2'd0, din: 8'h3C, sl: 8'hC3, exp: 8'hC3, ss: 4'b1110};
      vecs[2] = '{cpol: 1'b0, cpha: 1'b1, idx: 2'd1, din: 8'h3C, sl: 8'hC3, exp: 8'hC3, ss: 4'b1101};
      vecs[3] = '{cpol: 1'b1, cpha: 1'b0, idx: 2'd2, din: 8'h3C, sl: 8'hC3, exp: 8'hC3, ss: 4'b1011};
      vecs[4] = '{cpol: 1'b1, cpha: 1'b1, idx: 2'd3, din: 8'h3C, sl: 8'hC3, exp: 8'hC3, ss: 4'b0111};
      vecs[5] = '{cpol: 1'b0, cpha: 1'b1, idx: 2'd2, din: 8'hA5, sl: 8'h5A, exp: 8'h5A, ss: 4'b1011};
      vg      = '{cpol: 1'b0, cpha: 1'b0, idx: 2'd2, din: 8'h3C, sl: 8'hC3, exp: 8'hC3, ss: 4'b1011};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sck", 32'(sck_a), 32'(1'b0));
      chk("rst_mosi", 32'(mosi_a), 32'(1'b0));
      chk("rst_ss", 32'(ss_a), 32'hF);
      chk("rst_busy", 32'(busy_a), 32'(1'b0));
      chk("rst_valid", 32'(valid_a), 32'(1'b0));
      chk("rst_dout", 32'(dout_a), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_a(vecs[i], 0);
         repeat (2) @(negedge clk);
      end

      // Second en while busy must be ignored: no second transfer, data and select unaffected
      vc0 = vcnt_a;
      run_a(vg, 10);
      repeat (90) @(negedge clk);
      chk("busy_filter_valid_count", 32'(vcnt_a - vc0), 32'd1);
      chk("busy_filter_ss_idle", 32'(ss_a), 32'hF);

      // Reset during edge 7 of a mode-0 transfer
      @(negedge clk);
      cpol_a = 1'b0; cpha_a = 1'b0; idx_a = 2'd0; din_a = 8'h55;
      sl_data = 8'hAA; sl_cpha = 1'b0; sl_sel = 2'd0;
      en_a = 1'b1;
      t0 = cyc;
      vc0 = vcnt_a;
      @(negedge clk);
      en_a = 1'b0;
      while (cyc < t0 + 1 + 7 * int'(CD_A)) @(negedge clk);
      chk("mid_sck_edge7", 32'(sck_a), 32'(1'b1));
      chk("mid_dout_before", 32'(dout_a), 32'(LB ? 8'h3C : 8'hC3));
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_sck", 32'(sck_a), 32'(1'b0));
      chk("mid_rst_ss", 32'(ss_a), 32'hF);
      chk("mid_rst_busy", 32'(busy_a), 32'(1'b0));
      chk("mid_rst_dout", 32'(dout_a), 32'h0);
      chk("mid_rst_valid", 32'(valid_a), 32'(1'b0));
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      chk("mid_no_valid", 32'(vcnt_a - vc0), 32'd0);
      run_a(vecs[0], 0);

      // Instance B: back-to-back 16-bit words at CLK_DIV=1, en held in the DONE cycle
      @(negedge clk);
      cpol_b = 1'b0; cpha_b = 1'b0; idx_b = 2'd0; din_b = 16'hA5F0;
      en_b = 1'b1;
      t0 = cyc;
      vc0 = vcnt_b;
      for (int c = 1; c <= 69; c++) begin
         @(negedge clk);
         en_b = 1'b0;
         if (c == 1) begin
            chk("b_busy_start", 32'(busy_b), 32'(1'b1));
            chk("b_ss_start", 32'(ss_b), 32'(3'b110));
         end
         if (c == 2) chk("b_sck_edge1", 32'(sck_b), 32'(1'b1));
         if (c == 33) chk("b_ss_hold1", 32'(ss_b), 32'(3'b110));
         if (c == 34) begin
            chk("b_valid1", 32'(valid_b), 32'(1'b1));
            chk("b_dout1", 32'(dout_b), 32'hA5F0);
            chk("b_ss_gap", 32'(ss_b), 32'(3'b111));
            chk("b_busy_gap", 32'(busy_b), 32'(1'b0));
            en_b = 1'b1; din_b = 16'h0F5A;
         end
         if (c == 35) begin
            chk("b_ss_second", 32'(ss_b), 32'(3'b110));
            chk("b_busy_second", 32'(busy_b), 32'(1'b1));
            chk("b_valid_pulse", 32'(valid_b), 32'(1'b0));
         end
         if (c == 67) chk("b_valid_early", 32'(valid_b), 32'(1'b0));
         if (c == 68) begin
            chk("b_valid2", 32'(valid_b), 32'(1'b1));
            chk("b_dout2", 32'(dout_b), 32'h0F5A);
         end
         if (c == 69) chk("b_ss_idle", 32'(ss_b), 32'(3'b111));
      end
      chk("b_valid_count", 32'(vcnt_b - vc0), 32'd2);

      // Instance B: out-of-range select, mode 3; transfer runs with all SS high
      @(negedge clk);
      cpol_b = 1'b1; cpha_b = 1'b1; idx_b = 2'd3; din_b = 16'h8001;
      en_b = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         en_b = 1'b0;
         if (c == 1) begin
            chk("b_oor_busy", 32'(busy_b), 32'(1'b1));
            chk("b_oor_ss", 32'(ss_b), 32'(3'b111));
            chk("b_oor_sck_idle", 32'(sck_b), 32'(1'b1));
         end
         if (c == 17) chk("b_oor_ss_mid", 32'(ss_b), 32'(3'b111));
         if (c == 34) begin
            chk("b_oor_valid", 32'(valid_b), 32'(1'b1));
            chk("b_oor_dout", 32'(dout_b), 32'h8001);
         end
         if (c == 35) chk("b_oor_sck_end", 32'(sck_b), 32'(1'b1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
